memory_access: RTL and testbench
================================

# memory_access

Pipeline MEM stage between `execute` and writeback. Consumes the `REG_EX_MEM` register, performs at most one data-bus load or store per instruction through a valid/data_ok handshake, and aligns, sign- or zero-extends load data. Produces the `REG_MEM_WB` register and a forwarding source. Stalls the whole pipeline through `ok_to_proceed` while a bus access is outstanding.

## Interface
- No parameters. Widths come from the shared package: XLEN 64, 8-byte data bus.
- `clk`  input  1  pipeline clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset; asserted when 0.
- `moduleIn`  input  REG_EX_MEM  fields used: valid, aluOut (address or result), rs2 (store data), isWriteBack, wd, isMemRead, isMemWrite, memMode, instrAddr, instr.
- `moduleOut`  output  REG_MEM_WB  fields: valid, wdData, isWriteBack, wd, instrAddr, instr.
- `forwardSource`  output  FORWARD_SOURCE  fields: valid, isWb, wd, wdData.
- `ok_to_proceed`  output  1  this stage can retire its instruction this cycle.
- `ok_to_proceed_overall`  input  1  AND of all stages' ok_to_proceed.
- `dreq`  output  DBUS_REQ  fields: valid, addr[63:0], size[1:0], strobe[7:0], data[63:0].
- `dresp`  input  DBUS_RESP  fields: data_ok, data[63:0].

## Operation
- memMode[1:0] gives the size: 0=byte, 1=half, 2=word, 3=double. memMode[2]=1 means zero-extend the load (unsigned).
- memop = moduleIn.valid & (isMemRead | isMemWrite). Decode guarantees natural alignment. This block does not check alignment.
- Request payload, combinational from moduleIn:
  - addr = aluOut; size = memMode[1:0]; off = addr[2:0].
  - strobe = ((1<<(1<<size))-1) << off. Strobe is 0 for reads.
  - data = rs2 << (8*off).
- Load result: (dresp.data >> 8*off), truncated to the size, then sign-extended or zero-extended to 64 bits.
- FSM states are IDLE, WAIT and DONE.
  - IDLE: dreq.valid = memop.
    - memop with dresp.data_ok in the same cycle is a completion, handled as WAIT completion below.
    - memop without data_ok: go to WAIT.
  - WAIT: dreq.valid = 1, payload held stable.
    - dresp.data_ok with ok_to_proceed_overall: go to IDLE and register moduleOut.
    - dresp.data_ok without ok_to_proceed_overall: capture the load result in `ldbuf` and go to DONE.
  - DONE: dreq.valid = 0, so the request is never reissued. Go to IDLE on ok_to_proceed_overall.
- ok_to_proceed = ~memop | dresp.data_ok | (state==DONE).
- wdData source:
  - data_ok cycle: the extended response.
  - DONE: ldbuf.
  - Otherwise: aluOut.
- On a clock edge with ok_to_proceed_overall, moduleOut receives valid, wdData, isWriteBack, wd, instrAddr and instr. Stores write wdData = aluOut; it is unused.
- forwardSource:
  - valid = moduleIn.valid & wd!=0.
  - isWb = isWriteBack; wd = moduleIn.wd; wdData = current wdData.
  - A pending load's forwarded value is stale, but consumers are frozen until the stage proceeds, which happens only when the value is correct.

## Timing
- Reset (rst=0) applies immediately and asynchronously:
  - state=IDLE, moduleOut.valid=0, ldbuf=0.
  - dreq.valid follows memop, so it drops once upstream is reset.
- Non-memory instruction: one cycle. moduleOut is updated at the next edge with ok_to_proceed_overall.
- Memory instruction whose data_ok arrives k cycles after dreq.valid first rises (k≥0): the pipeline stalls for k cycles, then retires at the data_ok edge when overall=1.
- Reset during WAIT abandons the request. The bus must tolerate a request withdrawn mid-flight.
- moduleIn must not change while ok_to_proceed_overall=0. The upstream stall guarantees this.
- data_ok when dreq.valid=0 is ignored.

## Structure
- Shared package gets:
  - REG_MEM_WB, DBUS_REQ and DBUS_RESP structs.
  - MEM_SIZE constants: MSIZE1/2/4/8.
  - memMode bit definitions.
  - mem_state_t enum: IDLE, WAIT, DONE.
- Sub-module `mem_align`: purely combinational. Computes strobe and shifted store data from (addr[2:0], size, rs2), and the extended load value from (addr[2:0], memMode, rdata). It is shared with any future cache.

## Test plan
- ADD result, wd=5, aluOut=0x1234, no memop, overall=1 → ok_to_proceed=1, dreq.valid=0; next cycle moduleOut.valid=1, wdData=0x1234, wd=5.
- LB at addr 0x1003, memMode=0, data_ok after 3 cycles with data 0x00000000_80FF0000 → strobe 0 for reads; ok_to_proceed=0 for 3 cycles; wdData=0xFFFF_FFFF_FFFF_FF80.
- LHU at 0x2006, memMode=5, zero-wait data_ok, rdata 0xBEEF_0000_0000_0000 → retires in 1 cycle; wdData=0x0000_0000_0000_BEEF.
- SW at 0x3004, rs2=0xDEADBEEF, data_ok after 2 cycles → dreq.strobe=0xF0, dreq.data=0xDEADBEEF_00000000, payload stable across all 3 request cycles.
- LD with data_ok while overall=0 for 2 cycles → state DONE, dreq.valid=0 (no reissue), ok_to_proceed=1; moduleOut updated with the buffered data on the first overall=1 edge.
- rst=0 asserted during WAIT → moduleOut.valid=0 and state IDLE immediately without a clock edge; after release, an identical load reissues cleanly.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared types for the MEM stage: pipeline registers, data-bus request/response
// and access-size encodings.
package memory_access_pkg;

  localparam int XLEN       = 64;
  localparam int DBUS_BYTES = 8;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  // memMode[1:0] is the access size, memMode[2] selects zero-extension of loads
  localparam int MEMMODE_SIZE_LSB = 0;
  localparam int MEMMODE_UNSIGNED = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] aluOut;
    logic [XLEN-1:0] rs2;
    logic            isWriteBack;
    logic [4:0]      wd;
    logic            isMemRead;
    logic            isMemWrite;
    logic [2:0]      memMode;
    logic [XLEN-1:0] instrAddr;
    logic [31:0]     instr;
  } REG_EX_MEM;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] wdData;
    logic            isWriteBack;
    logic [4:0]      wd;
    logic [XLEN-1:0] instrAddr;
    logic [31:0]     instr;
  } REG_MEM_WB;

  typedef struct packed {
    logic            valid;
    logic            isWb;
    logic [4:0]      wd;
    logic [XLEN-1:0] wdData;
  } FORWARD_SOURCE;

  typedef struct packed {
    logic                  valid;
    logic [63:0]           addr;
    logic [1:0]            size;
    logic [DBUS_BYTES-1:0] strobe;
    logic [63:0]           data;
  } DBUS_REQ;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } DBUS_RESP;

  function automatic logic [DBUS_BYTES-1:0] lane_mask(input logic [1:0] size);
    case (size)
      MSIZE1:  lane_mask = 8'h01;
      MSIZE2:  lane_mask = 8'h03;
      MSIZE4:  lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_align.sv
// Byte-lane steering for the data bus: store strobe/data placement and
// load extraction with sign or zero extension.
module mem_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  mem_mode_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [63:0] shifted;
  logic        sign;

  always_comb begin
    strobe_o = lane_mask(size_i) << off_i;
    wdata_o  = wdata_i << {off_i, 3'b000};
    shifted  = rdata_i >> {off_i, 3'b000};
    sign     = 1'b0;
    case (mem_mode_i[1:0])
      MSIZE1: begin
        sign    = shifted[7] & ~mem_mode_i[MEMMODE_UNSIGNED];
        rdata_o = {{56{sign}}, shifted[7:0]};
      end
      MSIZE2: begin
        sign    = shifted[15] & ~mem_mode_i[MEMMODE_UNSIGNED];
        rdata_o = {{48{sign}}, shifted[15:0]};
      end
      MSIZE4: begin
        sign    = shifted[31] & ~mem_mode_i[MEMMODE_UNSIGNED];
        rdata_o = {{32{sign}}, shifted[31:0]};
      end
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: one data-bus access per instruction, stalls the pipe
// while the access is outstanding, and produces REG_MEM_WB plus forwarding.
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  REG_EX_MEM     moduleIn,
  output REG_MEM_WB     moduleOut,
  output FORWARD_SOURCE forwardSource,
  output logic          ok_to_proceed,
  input  logic          ok_to_proceed_overall,
  output DBUS_REQ       dreq,
  input  DBUS_RESP      dresp
);

  mem_state_t  state_q, state_d;
  logic [63:0] ldbuf_q, ldbuf_d;
  REG_MEM_WB   out_q, out_d;

  logic        memop;
  logic        is_load;
  logic        req_valid;
  logic        resp_ok;
  logic [63:0] wd_data;
  logic [7:0]  align_strobe;
  logic [63:0] align_wdata;
  logic [63:0] load_ext;

  assign memop   = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);
  assign is_load = moduleIn.isMemRead;

  mem_align u_align (
    .off_i      (moduleIn.aluOut[2:0]),
    .size_i     (moduleIn.memMode[1:0]),
    .wdata_i    (moduleIn.rs2),
    .mem_mode_i (moduleIn.memMode),
    .rdata_i    (dresp.data),
    .strobe_o   (align_strobe),
    .wdata_o    (align_wdata),
    .rdata_o    (load_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ldbuf_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ldbuf_q <= ldbuf_d;
      out_q   <= out_d;
    end
  end

  // A response in IDLE is a zero-wait completion and follows the WAIT rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (!resp_ok)                    state_d = WAIT;
          else if (!ok_to_proceed_overall) state_d = DONE;
        end
      end
      WAIT: if (resp_ok) state_d = ok_to_proceed_overall ? IDLE : DONE;
      DONE: if (ok_to_proceed_overall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    case (state_q)
      IDLE:    req_valid = memop;
      WAIT:    req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
    resp_ok       = dresp.data_ok & req_valid;
    ok_to_proceed = ~memop | resp_ok | (state_q == DONE);
    if (resp_ok && is_load)               wd_data = load_ext;
    else if (state_q == DONE && is_load)  wd_data = ldbuf_q;
    else                                  wd_data = moduleIn.aluOut;
  end

  // The buffer holds a completed load until the rest of the pipe lets us retire.
  always_comb begin
    ldbuf_d = ldbuf_q;
    out_d   = out_q;
    if (resp_ok && is_load && !ok_to_proceed_overall) ldbuf_d = load_ext;
    if (ok_to_proceed_overall) begin
      out_d.valid       = moduleIn.valid;
      out_d.wdData      = wd_data;
      out_d.isWriteBack = moduleIn.isWriteBack;
      out_d.wd          = moduleIn.wd;
      out_d.instrAddr   = moduleIn.instrAddr;
      out_d.instr       = moduleIn.instr;
    end
  end

  assign dreq = '{
    valid:  req_valid,
    addr:   moduleIn.aluOut,
    size:   moduleIn.memMode[1:0],
    strobe: moduleIn.isMemWrite ? align_strobe : 8'h00,
    data:   align_wdata
  };

  assign moduleOut = out_q;

  assign forwardSource = '{
    valid:  moduleIn.valid & (moduleIn.wd != 5'd0),
    isWb:   moduleIn.isWriteBack,
    wd:     moduleIn.wd,
    wdData: wd_data
  };

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for the MEM stage with a behavioural byte-level model,
// a per-cycle compare process and a few hand-computed directed cases.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  REG_EX_MEM     mi;
  REG_MEM_WB     mo;
  FORWARD_SOURCE fs;
  logic          ok, overall, other_ok;
  DBUS_REQ       dreq;
  DBUS_RESP      dresp;
  logic          chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  assign overall = ok & other_ok;

  memory_access dut (
    .clk                   (clk),
    .rst                   (rst),
    .moduleIn              (mi),
    .moduleOut             (mo),
    .forwardSource         (fs),
    .ok_to_proceed         (ok),
    .ok_to_proceed_overall (overall),
    .dreq                  (dreq),
    .dresp                 (dresp)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [2:0] mode);
    int n, off;
    logic [127:0] v;
    n   = 1 << mode[1:0];
    off = int'(addr[2:0]);
    v   = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!mode[2] && v[8*n-1]) v = v | ~((128'd1 << (8*n)) - 128'd1);
    return v[63:0];
  endfunction

  function automatic logic [7:0] model_strobe(input logic [63:0] addr, input logic [1:0] size);
    int n, off;
    logic [7:0] s;
    n = 1 << size;
    off = int'(addr[2:0]);
    s = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input logic [63:0] addr);
    int off;
    logic [63:0] d;
    off = int'(addr[2:0]);
    d = '0;
    for (int i = 0; off + i < 8; i++) d[8*(off+i) +: 8] = rs2[8*i +: 8];
    return d;
  endfunction

  logic        m_done;
  logic [63:0] m_buf;
  REG_MEM_WB   m_out;
  logic        e_memop, e_dv, e_resp, e_ok;
  logic [63:0] e_wd;

  always_comb begin
    e_memop = mi.valid & (mi.isMemRead | mi.isMemWrite);
    e_dv    = e_memop & ~m_done;
    e_resp  = e_dv & dresp.data_ok;
    e_ok    = ~e_memop | m_done | e_resp;
    e_wd    = mi.aluOut;
    if (mi.isMemRead && e_resp)                e_wd = model_load(dresp.data, mi.aluOut, mi.memMode);
    else if (mi.isMemRead && m_done && e_memop) e_wd = m_buf;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done <= 1'b0;
      m_buf  <= '0;
      m_out  <= '0;
    end else if (overall) begin
      m_done <= 1'b0;
      m_out  <= '{valid: mi.valid, wdData: e_wd, isWriteBack: mi.isWriteBack, wd: mi.wd,
                  instrAddr: mi.instrAddr, instr: mi.instr};
    end else if (e_resp) begin
      m_done <= 1'b1;
      m_buf  <= e_wd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #3;
    if (rst && chk_en) begin
      check64("ok_to_proceed", ok, e_ok);
      check64("dreq_valid", dreq.valid, e_dv);
      if (e_dv) begin
        check64("dreq_addr", dreq.addr, mi.aluOut);
        check64("dreq_size", dreq.size, mi.memMode[1:0]);
        check64("dreq_strobe", dreq.strobe, mi.isMemWrite ? model_strobe(mi.aluOut, mi.memMode[1:0]) : 8'h00);
        check64("dreq_data", dreq.data, model_wdata(mi.rs2, mi.aluOut));
      end
      check64("fwd_valid", fs.valid, mi.valid && mi.wd != 5'd0);
      if (mi.valid && mi.wd != 5'd0) begin
        check64("fwd_isWb", fs.isWb, mi.isWriteBack);
        check64("fwd_wd", fs.wd, mi.wd);
        check64("fwd_wdData", fs.wdData, e_wd);
      end
      check64("mo_valid", mo.valid, m_out.valid);
      if (m_out.valid) begin
        check64("mo_wdData", mo.wdData, m_out.wdData);
        check64("mo_wd", mo.wd, m_out.wd);
        check64("mo_isWb", mo.isWriteBack, m_out.isWriteBack);
        check64("mo_instrAddr", mo.instrAddr, m_out.instrAddr);
        check64("mo_instr", mo.instr, m_out.instr);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic REG_EX_MEM mk(input logic v, input logic rd, input logic wr, input logic [2:0] mode,
                                   input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] wd);
    REG_EX_MEM r;
    r = '0;
    r.valid = v; r.isMemRead = rd; r.isMemWrite = wr; r.memMode = mode;
    r.aluOut = alu; r.rs2 = rs2; r.wd = wd; r.isWriteBack = ~wr;
    r.instrAddr = {32'h0, $urandom} & ~64'h3;
    r.instr = $urandom;
    return r;
  endfunction

  // Presents one instruction and runs it until the pipe advances past it.
  task automatic issue(input REG_EX_MEM ins, input int lat, input logic [63:0] rdata, input int hold,
                       output int stalls, output logic stable, output logic reissue,
                       output logic [7:0] strobe0, output logic [63:0] data0);
    int c;
    logic mem, done, seen;
    c = 0; done = 1'b0; seen = 1'b0;
    stalls = 0; stable = 1'b1; reissue = 1'b0; strobe0 = '0; data0 = '0;
    mem = ins.valid & (ins.isMemRead | ins.isMemWrite);
    while (!done) begin
      @(negedge clk);
      if (c == 0) mi = ins;
      other_ok = (c >= (mem ? lat : 0) + hold);
      dresp.data_ok = mem ? (c == lat || (c > lat && $urandom_range(1) == 1)) : ($urandom_range(1) == 1);
      dresp.data = (c == lat) ? rdata : {$urandom, $urandom};
      #2;
      if (!ok) stalls++;
      if (dreq.valid) begin
        if (!seen) begin
          seen = 1'b1; strobe0 = dreq.strobe; data0 = dreq.data;
        end else if (dreq.strobe !== strobe0 || dreq.data !== data0) stable = 1'b0;
        if (mem && c > lat) reissue = 1'b1;
      end
      done = overall;
      c++;
      if (!done && c > lat + hold + 8) begin
        checks++; errors++;
        $display("FAIL timeout actual=%0d cycles required<=%0d", c, lat + hold + 8);
        done = 1'b1;
      end
    end
  endtask

  int          st;
  logic        stab, reis;
  logic [7:0]  sb;
  logic [63:0] db, rv;
  REG_EX_MEM   ins;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    mi = '0; other_ok = 1'b1; dresp = '0;
    repeat (2) @(negedge clk);
    #2;
    check64("rst_mo_valid", mo.valid, 1'b0);
    check64("rst_dreq_valid", dreq.valid, 1'b0);
    check64("rst_ok", ok, 1'b1);
    rst = 1'b1;
    chk_en = 1'b1;

    // ALU result, no memory access
    issue(mk(1, 0, 0, 3'd0, 64'h1234, 64'h0, 5'd5), 0, 64'h0, 0, st, stab, reis, sb, db);
    check64("add_stalls", st, 0);
    @(posedge clk); #1;
    check64("add_mo_valid", mo.valid, 1'b1);
    check64("add_mo_wdData", mo.wdData, 64'h1234);
    check64("add_mo_wd", mo.wd, 5'd5);

    // LB, 3-cycle latency, negative byte
    issue(mk(1, 1, 0, 3'd0, 64'h1003, 64'h0, 5'd7), 3, 64'h00000000_80FF0000, 0, st, stab, reis, sb, db);
    check64("lb_stalls", st, 3);
    check64("lb_strobe", sb, 8'h00);
    @(posedge clk); #1;
    check64("lb_wdData", mo.wdData, 64'hFFFF_FFFF_FFFF_FF80);

    // LHU, zero-wait
    issue(mk(1, 1, 0, 3'd5, 64'h2006, 64'h0, 5'd8), 0, 64'hBEEF_0000_0000_0000, 0, st, stab, reis, sb, db);
    check64("lhu_stalls", st, 0);
    @(posedge clk); #1;
    check64("lhu_wdData", mo.wdData, 64'h0000_0000_0000_BEEF);

    // SW, 2-cycle latency
    issue(mk(1, 0, 1, 3'd2, 64'h3004, 64'hDEADBEEF, 5'd0), 2, 64'h0, 0, st, stab, reis, sb, db);
    check64("sw_stalls", st, 2);
    check64("sw_strobe", sb, 8'hF0);
    check64("sw_data", db, 64'hDEADBEEF_00000000);
    check64("sw_stable", stab, 1'b1);

    // LD completing while the rest of the pipe is stalled
    rv = 64'h0123_4567_89AB_CDEF;
    issue(mk(1, 1, 0, 3'd3, 64'h4008, 64'h0, 5'd9), 1, rv, 2, st, stab, reis, sb, db);
    check64("ld_done_reissue", reis, 1'b0);
    check64("ld_done_stalls", st, 1);
    @(posedge clk); #1;
    check64("ld_done_wdData", mo.wdData, rv);

    // Reset while waiting on the bus
    ins = mk(1, 1, 0, 3'd3, 64'h5000, 64'h0, 5'd10);
    @(negedge clk);
    mi = ins; other_ok = 1'b1; dresp = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check64("rst_wait_mo_valid", mo.valid, 1'b0);
    check64("rst_wait_state", 64'(dut.state_q), 64'(IDLE));
    check64("rst_wait_dreq_follow", dreq.valid, 1'b1);
    mi.valid = 1'b0;
    #1;
    check64("rst_wait_dreq_drop", dreq.valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    issue(ins, 1, 64'h8000_0000_0000_0001, 0, st, stab, reis, sb, db);
    check64("reissue_stalls", st, 1);
    @(posedge clk); #1;
    check64("reissue_wdData", mo.wdData, 64'h8000_0000_0000_0001);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [1:0] sz;
      logic [63:0] addr;
      kind = $urandom_range(2);
      sz   = 2'($urandom_range(3));
      addr = {$urandom, $urandom} & ~((64'd1 << sz) - 64'd1);
      ins  = mk($urandom_range(9) != 0, kind == 1, kind == 2,
                {(kind == 1) && ($urandom_range(1) == 1), sz}, addr,
                {$urandom, $urandom}, 5'($urandom_range(31)));
      issue(ins, $urandom_range(4), {$urandom, $urandom}, $urandom_range(2), st, stab, reis, sb, db);
    end
    @(negedge clk);
    mi = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
